// File: rtl/video_timing_pattern_pkg.sv
// Shared definitions for the video timing / test-pattern generator:
// pattern encodings, the colour-bar table and small arithmetic helpers.
package video_timing_pattern_pkg;

    localparam int X_W = 12;
    localparam int Y_W = 11;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_BOX      = 2'd3
    } pattern_e;

    // {red, green, blue} on/off per bar, left to right:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_TABLE [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_index(input logic [31:0] col, input logic [31:0] width);
        return 3'((col * 32'd8) / width);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters plus registered sync / data-enable / position outputs.
// Counter values are also exposed unregistered so pixel logic can align to them.
module video_timing_gen
    import video_timing_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic [X_W-1:0] h_o,
    output logic [Y_W-1:0] v_o,
    output logic           active_o,
    output logic           frame_end_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           de_o,
    output logic           frame_start_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [X_W-1:0] h_q, h_d, x_q;
    logic [Y_W-1:0] v_q, v_d, y_q;
    logic           hsync_q, vsync_q, de_q, frame_start_q;
    logic           active, h_sync_on, v_sync_on;

    always_comb begin
        h_d = h_q + X_W'(1);
        v_d = v_q;
        if (h_q == X_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == Y_W'(V_TOTAL - 1)) ? '0 : v_q + Y_W'(1);
        end
    end

    assign active    = (h_q < X_W'(H_ACTIVE)) && (v_q < Y_W'(V_ACTIVE));
    assign h_sync_on = (h_q >= X_W'(H_ACTIVE + H_FP)) && (h_q < X_W'(H_ACTIVE + H_FP + H_SYNC));
    // vsync spans whole lines, independent of h
    assign v_sync_on = (v_q >= Y_W'(V_ACTIVE + V_FP)) && (v_q < Y_W'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            h_q           <= '0;
            v_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= active ? h_q : '0;
            y_q           <= active ? v_q : '0;
            de_q          <= active;
            frame_start_q <= (h_q == '0) && (v_q == '0);
            hsync_q       <= h_sync_on ? HSYNC_POL : ~HSYNC_POL;
            vsync_q       <= v_sync_on ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign active_o      = active;
    assign frame_end_o   = (h_q == X_W'(H_TOTAL - 1)) && (v_q == Y_W'(V_TOTAL - 1));
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign frame_start_o = frame_start_q;
    assign x_o           = x_q;
    assign y_o           = y_q;

endmodule

// File: rtl/video_timing_pattern.sv
// Test-pattern generator: colour bars, checkerboard, gradient and a bouncing
// box, with a button that advances the pattern only at frame boundaries.
module video_timing_pattern
    import video_timing_pattern_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_BITS = 8,
    parameter int BOX_SIZE   = 32,
    parameter int BOX_STEP   = 2
) (
    input  logic                  pixclk,
    input  logic                  rstn,
    input  logic                  pattern_step,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  frame_start,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [1:0]            pattern
);
    localparam int                    BX_MAX = H_ACTIVE - BOX_SIZE;
    localparam int                    BY_MAX = V_ACTIVE - BOX_SIZE;
    localparam logic [COLOR_BITS-1:0] FULL   = '1;

    logic [X_W-1:0]        h, bx_q, bx_d;
    logic [Y_W-1:0]        v, by_q, by_d;
    logic                  active, frame_end;
    logic                  step_s1_q, step_s2_q, step_s3_q, step_rise, pending_q;
    logic                  bx_dn_q, bx_dn_d, by_dn_q, by_dn_d, in_box;
    pattern_e              pat_q;
    logic [1:0]            pattern_q;
    logic [2:0]            bar_rgb;
    logic [COLOR_BITS-1:0] red_d, green_d, blue_d, red_q, green_q, blue_q;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
    ) u_timing (
        .clk_i(pixclk), .rst_ni(rstn), .h_o(h), .v_o(v), .active_o(active),
        .frame_end_o(frame_end), .hsync_o(hsync), .vsync_o(vsync), .de_o(de),
        .frame_start_o(frame_start), .x_o(x), .y_o(y)
    );

    assign step_rise = step_s2_q & ~step_s3_q;

    // Box bounces: clamp to the edge and reverse when the next step would reach it
    always_comb begin
        bx_d = bx_q + X_W'(BOX_STEP);
        bx_dn_d = bx_dn_q;
        if (!bx_dn_q) begin
            if (32'(bx_q) + 32'(BOX_STEP) >= 32'(BX_MAX)) begin
                bx_d = X_W'(BX_MAX);
                bx_dn_d = 1'b1;
            end
        end else if (32'(bx_q) <= 32'(BOX_STEP)) begin
            bx_d = '0;
            bx_dn_d = 1'b0;
        end else begin
            bx_d = bx_q - X_W'(BOX_STEP);
        end

        by_d = by_q + Y_W'(BOX_STEP);
        by_dn_d = by_dn_q;
        if (!by_dn_q) begin
            if (32'(by_q) + 32'(BOX_STEP) >= 32'(BY_MAX)) begin
                by_d = Y_W'(BY_MAX);
                by_dn_d = 1'b1;
            end
        end else if (32'(by_q) <= 32'(BOX_STEP)) begin
            by_d = '0;
            by_dn_d = 1'b0;
        end else begin
            by_d = by_q - Y_W'(BOX_STEP);
        end
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        bar_rgb = BAR_TABLE[bar_index(32'(h), 32'(H_ACTIVE))];
        in_box  = (32'(h) >= 32'(bx_q)) && (32'(h) < 32'(bx_q) + 32'(BOX_SIZE)) &&
                  (32'(v) >= 32'(by_q)) && (32'(v) < 32'(by_q) + 32'(BOX_SIZE));
        if (active) begin
            unique case (pat_q)
                PAT_BARS: begin
                    red_d   = bar_rgb[2] ? FULL : '0;
                    green_d = bar_rgb[1] ? FULL : '0;
                    blue_d  = bar_rgb[0] ? FULL : '0;
                end
                PAT_CHECKER: begin
                    if (h[5] ^ v[5]) begin
                        red_d   = FULL;
                        green_d = FULL;
                        blue_d  = FULL;
                    end
                end
                PAT_GRADIENT: begin
                    red_d   = COLOR_BITS'(h);
                    green_d = COLOR_BITS'(v);
                    blue_d  = COLOR_BITS'(h + X_W'(v));
                end
                PAT_BOX: begin
                    blue_d = FULL;
                    if (in_box) begin
                        red_d   = FULL;
                        green_d = FULL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rstn) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
            pending_q <= 1'b0;
            pat_q     <= PAT_BARS;
            pattern_q <= 2'd0;
            bx_q      <= '0;
            by_q      <= '0;
            bx_dn_q   <= 1'b0;
            by_dn_q   <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            step_s1_q <= pattern_step;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            pattern_q <= pat_q;
            // An edge seen in the boundary cycle itself stays pending for the next frame
            if (frame_end) begin
                bx_q      <= bx_d;
                by_q      <= by_d;
                bx_dn_q   <= bx_dn_d;
                by_dn_q   <= by_dn_d;
                pending_q <= step_rise;
                if (pending_q) begin
                    pat_q <= pattern_e'(pat_q + 2'd1);
                end
            end else if (step_rise) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign red     = red_q;
    assign green   = green_q;
    assign blue    = blue_q;
    assign pattern = pattern_q;

endmodule

// File: doc/video_timing_pattern.md
VIDEO_TIMING_PATTERN -- requirements
Module: video_timing_pattern

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (timing in pixels/lines); HSYNC_POL 0, VSYNC_POL 0 (active level); COLOR_BITS 8 (bits per channel); BOX_SIZE 32, BOX_STEP 2 (moving-box pixels).
REQ-002 SHALL have ports: pixclk input 1 pixel clock; rstn input 1 reset; pattern_step input 1 async button; red, green, blue output COLOR_BITS pixel colour; hsync output 1; vsync output 1; de output 1 data enable; frame_start output 1 pulse; x output 12 active column; y output 11 active row; pattern output 2 current pattern.
REQ-003 SHALL use one clock, pixclk; reset SHALL be rstn, synchronous, active-low.

Function
REQ-004 SHALL keep h counter 0..H_TOTAL-1 (H_TOTAL = sum of H_*); at H_TOTAL-1 wrap to 0 and advance v; v wraps 0 after V_TOTAL-1.
REQ-005 SHALL register every output; outputs in cycle t reflect counter values of cycle t-1 (latency 1).
REQ-006 de SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE; x=h, y=v while de=1, else x=0, y=0.
REQ-007 hsync SHALL be at HSYNC_POL for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else inverse; vsync likewise on v with V_* and VSYNC_POL (whole lines, no h qualification).
REQ-008 frame_start SHALL pulse one cycle, coincident with the output cycle of h=0, v=0.
REQ-009 red/green/blue SHALL be 0 whenever de=0.
REQ-010 pattern 0, colour bars: bar = (x*8)/H_ACTIVE; order white, yellow, cyan, green, magenta, red, blue, black; channels full-scale (all ones) or 0.
REQ-011 pattern 1, checkerboard: white if x[5] XOR y[5] = 1, else black.
REQ-012 pattern 2, gradient: red = x[COLOR_BITS-1:0], green = y[COLOR_BITS-1:0], blue = (x+y)[COLOR_BITS-1:0], truncated.
REQ-013 pattern 3, moving box: white where bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, else blue full-scale, others 0.
REQ-014 box position SHALL update once per frame, in the cycle h=H_TOTAL-1, v=V_TOTAL-1, regardless of pattern selected.
REQ-015 box moving +: if bx+BOX_STEP >= H_ACTIVE-BOX_SIZE then bx = H_ACTIVE-BOX_SIZE and direction becomes -, else bx += BOX_STEP; moving -: if bx <= BOX_STEP then bx = 0 and direction becomes +, else bx -= BOX_STEP; by identical against V_ACTIVE.
REQ-016 pattern_step SHALL pass through a 2-flop synchroniser and rising-edge detector; a detected edge sets a pending flag.
REQ-017 pending flag SHALL be consumed at the same frame-boundary cycle as REQ-014: pattern increments modulo 4, flag clears; multiple edges in one frame SHALL give one increment.
REQ-018 edge detected in the frame-boundary cycle itself SHALL apply at the following boundary; pattern SHALL never change mid-frame.

Reset
REQ-019 rstn=0 at a pixclk edge SHALL set h=0, v=0, de=0, x=0, y=0, RGB=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, pattern=0, pending=0, synchroniser flops 0, bx=by=0, both box directions +.
REQ-020 reset asserted mid-frame SHALL take effect on that edge; first cycle after release SHALL compute h=0, v=0, so frame_start pulses on the 2nd cycle after release.

Structure
REQ-021 shared package SHALL hold pattern encodings (BARS 0, CHECKER 1, GRADIENT 2, BOX 3) and the 8-entry colour-bar table.
REQ-022 timing counters, sync and de generation SHALL be sub-module video_timing_gen; pattern logic, box state and button handling live in video_timing_pattern.

Verification
REQ-023 defaults, 1 frame: 420000 cycles between frame_start pulses; per line de high 640 cycles, hsync low 96 cycles starting 656 cycles after first de; vsync low for 2 lines (1600 cycles).
REQ-024 pattern 0, line 0: x=0..79 RGB=FF,FF,FF; x=80 RGB=FF,FF,00; x=560..639 RGB=00,00,00; blanking RGB=0.
REQ-025 3 pattern_step pulses mid-frame 0 -> pattern stays 0 until frame-end boundary, then 1; pulse in boundary cycle -> increment one frame later; 4 steps across 4 frames -> returns to 0.
REQ-026 pattern 3 from reset: frame 1 box at x=0..31; after 1 boundary bx=2; after 304 boundaries bx=608, direction -; after 305 bx=606; by reaches 448 after 224 boundaries then decrements.
REQ-027 rstn=0 for 1 cycle at h=300, v=200, pattern=2, bx=40 -> all outputs per REQ-019, pattern=0, bx=0, frame_start on 2nd cycle after release.
REQ-028 parameter variant H_ACTIVE 1280, H_FP 110, H_SYNC 40, H_BP 220, V 720/5/5/20, HSYNC_POL 1, VSYNC_POL 1 -> 1650x750 frame, hsync high 40 cycles, de high 1280 cycles per line.
